alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Multi-cycle integer ALU that directly consumes `ALUControl` from the ALU decoder stage. It executes add/sub/pass in one cycle and iterative unsigned multiply and divide over WIDTH cycles. A start/busy/done handshake tells the control unit when results are valid. ALUResult and flags feed the writeback mux and the condition/branch logic.

## Interface
- `WIDTH`, default 32: operand and result width (≥4).
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request one operation; sampled only when `busy`=0.
- `ALUControl`  in  3: 000 add, 001 sub, 010 mul, 011 div, 1xx pass SrcA.
- `SrcA`  in  WIDTH: operand A / dividend.
- `SrcB`  in  WIDTH: operand B / divisor.
- `busy`  out  1: iterative operation in progress; new starts ignored.
- `done`  out  1: one-cycle pulse; outputs below valid from this cycle.
- `ALUResult`  out  WIDTH: sum, difference, product low half, quotient, or SrcA.
- `DivRem`  out  WIDTH: remainder for div; 0 for all other ops.
- `Flags`  out  4: {N,Z,C,V}.
- `DivByZero`  out  1: set by div with SrcB=0; cleared by the next accepted op.

## Operation
- Operands and ALUControl latch on acceptance (`start`=1 while `busy`=0); later input changes have no effect.
- FSM states: IDLE, MUL, DIV. Reset forces IDLE.
- IDLE + start + add/sub/pass: compute, register outputs, pulse done next cycle, stay IDLE.
- IDLE + start + mul: go to MUL with count=WIDTH. Perform unsigned shift-add, one bit per cycle, with a 2·WIDTH accumulator. Return to IDLE at count 0 with done.
- IDLE + start + div, SrcB≠0: go to DIV. Perform unsigned restoring division, one quotient bit per cycle. Return to IDLE with done.
- IDLE + start + div, SrcB=0: no iteration. ALUResult=all ones, DivRem=SrcA, DivByZero=1, done next cycle.
- `start` in MUL/DIV is ignored, with no queueing.
- Flags, updated only with done:
  - Z=(ALUResult==0); N=ALUResult[WIDTH-1].
  - add: C=carry-out, V=signed overflow.
  - sub: C=1 when A≥B unsigned (no borrow), V=signed overflow.
  - mul: C=1 when product high half ≠0, V=0.
  - div/pass: C=V=0.
- Add/sub wrap modulo 2^WIDTH.
- Outputs hold their last values until the next done.

## Timing
- Reset values: busy=0, done=0, ALUResult=0, DivRem=0, Flags=0000, DivByZero=0, state IDLE, counter 0.
- Latency, with start sampled at edge k:
  - add/sub/pass/div-by-zero: done high in cycle k+1.
  - mul/div: busy high for cycles k+1..k+WIDTH; done high in cycle k+WIDTH+1 with busy=0.
- Single-cycle ops accept back-to-back: start held each cycle gives done each cycle.
- A start in the done cycle of mul/div is accepted (busy=0).
- Reset asserted mid-operation aborts immediately. All outputs go to reset values, with no done for the aborted op.

## Configuration
- `ALU_DIV_EN` defined: divider and DIV state present, behaviour as above.
- `ALU_DIV_EN` undefined: no divider logic. ALUControl 011 completes in one cycle with ALUResult=0, DivRem=0, DivByZero=0, Flags=0100.

## Test plan
- ADD 0x7FFFFFFF+0x00000001 → ALUResult 0x80000000, Flags N=1 Z=0 C=0 V=1, done exactly one cycle after start.
- SUB 5−5 → 0, Z=1 C=1 V=0. SUB 3−5 → 0xFFFFFFFE, N=1 C=0. Issue both back-to-back → two consecutive done pulses.
- MUL 0x00010000×0x00010000 → ALUResult 0, Z=1 C=1; busy high 32 cycles, done at cycle 33. MUL 6×7 → 42. A start with ADD during busy → ignored, with no extra done.
- DIV 100/7 (ALU_DIV_EN defined) → ALUResult 14, DivRem 2, done at cycle 33. DIV 5/0 → 0xFFFFFFFF, DivRem 5, DivByZero=1, done at cycle 1. A following ADD clears DivByZero.
- Assert rst_n=0 ten cycles into a MUL → busy, done, and all outputs 0 immediately. After release, ADD 2+2 → 4 with done one cycle later.
- ALU_DIV_EN undefined: DIV 100/7 → ALUResult 0, Flags 0100, done one cycle after start; PASS (ALUControl 100) SrcA=0xDEADBEEF → 0xDEADBEEF, N=1.

Source files
------------

// File: rtl/alu_multicycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_multicycle: add/sub/pass in one cycle; shift-add multiply and,       |
// | with ALU_DIV_EN defined, restoring divide over WIDTH cycles.             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] DivRem,
  output logic [3:0]       Flags,
  output logic             DivByZero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   op_res, op_rem;
  logic               op_c, op_v, op_fin;

  logic [WIDTH:0]     add_w, sub_w, mul_sum_w;
  logic [2*WIDTH-1:0] mul_acc_w;

  assign add_w     = {1'b0, SrcA} + {1'b0, SrcB};
  assign sub_w     = {1'b0, SrcA} - {1'b0, SrcB};
  // acc = {partial product high, remaining multiplier bits}; shifts right each step
  assign mul_sum_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_acc_w = {mul_sum_w, acc_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic [WIDTH:0]     div_sh_w, div_diff_w;
  logic [2*WIDTH-1:0] div_acc_w;

  // acc = {partial remainder, dividend bits shifting out / quotient bits in}
  assign div_sh_w   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_w = div_sh_w - {1'b0, opb_q};
  assign div_acc_w  = div_diff_w[WIDTH]
                    ? {div_sh_w[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff_w[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    op_res   = '0;
    op_rem   = '0;
    op_c     = 1'b0;
    op_v     = 1'b0;
    op_fin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          case (ALUControl)
            3'b000: begin
              op_res = add_w[WIDTH-1:0];
              op_c   = add_w[WIDTH];
              op_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (add_w[WIDTH-1] != SrcA[WIDTH-1]);
              op_fin = 1'b1;
            end
            3'b001: begin
              op_res = sub_w[WIDTH-1:0];
              op_c   = ~sub_w[WIDTH];
              op_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (sub_w[WIDTH-1] != SrcA[WIDTH-1]);
              op_fin = 1'b1;
            end
            3'b010: begin
              state_d = S_MUL;
              count_d = CW'(WIDTH);
              acc_d   = {{WIDTH{1'b0}}, SrcB};
              opb_d   = SrcA;
            end
            3'b011: begin
`ifdef ALU_DIV_EN
              if (SrcB == '0) begin
                op_res = '1;
                op_rem = SrcA;
                dbz_d  = 1'b1;
                op_fin = 1'b1;
              end else begin
                state_d = S_DIV;
                count_d = CW'(WIDTH);
                acc_d   = {{WIDTH{1'b0}}, SrcA};
                opb_d   = SrcB;
              end
`else
              op_fin = 1'b1;
`endif
            end
            default: begin
              op_res = SrcA;
              op_fin = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d   = mul_acc_w;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = S_IDLE;
          op_res  = mul_acc_w[WIDTH-1:0];
          op_c    = |mul_acc_w[2*WIDTH-1:WIDTH];
          op_fin  = 1'b1;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        acc_d   = div_acc_w;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = S_IDLE;
          op_res  = div_acc_w[WIDTH-1:0];
          op_rem  = div_acc_w[2*WIDTH-1:WIDTH];
          op_fin  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (op_fin) begin
      done_d   = 1'b1;
      result_d = op_res;
      rem_d    = op_rem;
      flags_d  = {op_res[WIDTH-1], ~|op_res, op_c, op_v};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign ALUResult = result_q;
  assign DivRem    = rem_q;
  assign Flags     = flags_q;
  assign DivByZero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// Testbench for alu_multicycle: directed spec cases plus randomized ops vs a
// plain-arithmetic reference model.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA, SrcB;
  logic         busy, done, DivByZero;
  logic [W-1:0] ALUResult, DivRem;
  logic [3:0]   Flags;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .ALUResult(ALUResult), .DivRem(DivRem), .Flags(Flags), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [W-1:0] rm,
                                output logic [3:0] f, output logic dz, output int lat);
    logic [63:0] wide;
    longint sa, sb, s;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; rm = '0; c = 1'b0; v = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      3'd0: begin
        wide = {32'd0, a} + {32'd0, b};
        r = wide[31:0]; c = wide[32];
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r = a - b; c = (a >= b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: begin
        wide = {32'd0, a} * {32'd0, b};
        r = wide[31:0]; c = (wide[63:32] != 0); lat = W + 1;
      end
      3'd3: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin
          r = '1; rm = a; dz = 1'b1;
        end else begin
          r = a / b; rm = a % b; lat = W + 1;
        end
`endif
      end
      default: r = a;
    endcase
    f = {r[W-1], (r == 0), c, v};
  endfunction

  // Issues one op, scrambles inputs after acceptance, returns latency (0 on timeout)
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    start = 1'b0; ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 0; busy_cnt = 0;
    for (int n = 1; n <= W + 5; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ALUControl = 3'd0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ALUResult, DivRem, Flags, DivByZero} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b res=%h rem=%h flags=%b dbz=%b exp all 0",
               busy, done, ALUResult, DivRem, Flags, DivByZero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat, bc;
    do_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, lat, bc);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
    checks++;
    if (ALUResult !== 32'h8000_0000 || Flags !== 4'b1001) begin
      errors++; $display("FAIL add_ovf got %h/%b exp 80000000/1001", ALUResult, Flags);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; ALUControl = 3'd1; SrcA = 32'd5; SrcB = 32'd5;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'd0 || Flags !== 4'b0110) begin
      errors++; $display("FAIL sub_5_5 got done=%b %h/%b exp 1 0/0110", done, ALUResult, Flags);
    end
    SrcA = 32'd3;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ALUResult !== 32'hFFFF_FFFE || Flags !== 4'b1000) begin
      errors++; $display("FAIL sub_3_5 got done=%b %h/%b exp 1 fffffffe/1000", done, ALUResult, Flags);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_mul();
    int lat, bc, ndone, at;
    do_op(3'd2, 32'h0001_0000, 32'h0001_0000, lat, bc);
    checks++;
    if (lat !== W + 1 || bc !== W) begin
      errors++; $display("FAIL mul_timing got lat=%0d busy=%0d exp %0d/%0d", lat, bc, W + 1, W);
    end
    checks++;
    if (ALUResult !== 32'd0 || Flags !== 4'b0110 || DivRem !== 32'd0) begin
      errors++; $display("FAIL mul_hi got %h/%b rem=%h exp 0/0110 rem 0", ALUResult, Flags, DivRem);
    end
    // 6*7 with an ADD start injected mid-operation
    @(negedge clk);
    start = 1'b1; ALUControl = 3'd2; SrcA = 32'd6; SrcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; at = 0;
    for (int n = 2; n <= W + 8; n++) begin
      if (n == 6) begin start = 1'b1; ALUControl = 3'd0; SrcA = 32'd1; SrcB = 32'd1; end
      if (n == 7) start = 1'b0;
      @(negedge clk);
      if (done) begin ndone++; at = n; end
    end
    checks++;
    if (ndone !== 1 || at !== W + 1) begin
      errors++; $display("FAIL mul_ignore_start got dones=%0d at=%0d exp 1 at %0d", ndone, at, W + 1);
    end
    checks++;
    if (ALUResult !== 32'd42 || Flags !== 4'b0000) begin
      errors++; $display("FAIL mul_6x7 got %h/%b exp 2a/0000", ALUResult, Flags);
    end
  endtask

  task automatic test_div();
    int lat, bc;
    do_op(3'd3, 32'd100, 32'd7, lat, bc);
`ifdef ALU_DIV_EN
    checks++;
    if (lat !== W + 1 || ALUResult !== 32'd14 || DivRem !== 32'd2 || Flags !== 4'b0000) begin
      errors++; $display("FAIL div_100_7 got lat=%0d %h rem=%h %b exp %0d e rem 2 0000",
                         lat, ALUResult, DivRem, Flags, W + 1);
    end
    do_op(3'd3, 32'd5, 32'd0, lat, bc);
    checks++;
    if (lat !== 1 || ALUResult !== 32'hFFFF_FFFF || DivRem !== 32'd5 || DivByZero !== 1'b1 || Flags !== 4'b1000) begin
      errors++; $display("FAIL div_by_zero got lat=%0d %h rem=%h dbz=%b %b exp 1 ffffffff 5 1 1000",
                         lat, ALUResult, DivRem, DivByZero, Flags);
    end
    do_op(3'd0, 32'd1, 32'd1, lat, bc);
    checks++;
    if (DivByZero !== 1'b0 || ALUResult !== 32'd2) begin
      errors++; $display("FAIL dbz_clear got dbz=%b res=%h exp 0 2", DivByZero, ALUResult);
    end
`else
    checks++;
    if (lat !== 1 || ALUResult !== 32'd0 || DivRem !== 32'd0 || Flags !== 4'b0100 || DivByZero !== 1'b0) begin
      errors++; $display("FAIL div_disabled got lat=%0d %h rem=%h %b dbz=%b exp 1 0 0 0100 0",
                         lat, ALUResult, DivRem, Flags, DivByZero);
    end
`endif
  endtask

  task automatic test_pass();
    int lat, bc;
    do_op(3'd4, 32'hDEAD_BEEF, 32'h1234_5678, lat, bc);
    checks++;
    if (lat !== 1 || ALUResult !== 32'hDEAD_BEEF || Flags !== 4'b1000) begin
      errors++; $display("FAIL pass got lat=%0d %h/%b exp 1 deadbeef/1000", lat, ALUResult, Flags);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, ndone;
    @(negedge clk);
    start = 1'b1; ALUControl = 3'd2; SrcA = 32'd123; SrcB = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ALUResult, DivRem, Flags, DivByZero} !== '0) begin
      errors++; $display("FAIL reset_abort got busy=%b done=%b res=%h rem=%h flags=%b dbz=%b exp all 0",
                         busy, done, ALUResult, DivRem, Flags, DivByZero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL reset_no_done got %0d active cycles exp 0", ndone); end
    do_op(3'd0, 32'd2, 32'd2, lat, bc);
    checks++;
    if (lat !== 1 || ALUResult !== 32'd4) begin
      errors++; $display("FAIL add_after_reset got lat=%0d res=%h exp 1 4", lat, ALUResult);
    end
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [W-1:0] a, b, er, erm;
    logic [3:0]   ef;
    logic         edz;
    int           elat, lat, bc;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 300));
      model(op, a, b, er, erm, ef, edz, elat);
      do_op(op, a, b, lat, bc);
      checks++;
      if (lat !== elat || ALUResult !== er || DivRem !== erm || Flags !== ef || DivByZero !== edz) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h got lat=%0d res=%h rem=%h f=%b dz=%b exp lat=%0d res=%h rem=%h f=%b dz=%b",
                 op, a, b, lat, ALUResult, DivRem, Flags, DivByZero, elat, er, erm, ef, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_div();
    test_pass();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
